// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, sequencer state type and opcode legality helper
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_MOVI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } seq_state_t;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    logic legal;
    unique case (op)
      OP_RTYPE, OP_ADDI, OP_SUBI, OP_MOVI, OP_J: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multicycle FETCH/DECODE/EXECUTE/WRITEBACK instruction sequencer
//
// Owns pc, ir and the retired-instruction counter. Steps each instruction through
// four states (plus fetch wait states), gates the control unit's RegWrite/Jump
// into single-cycle strobes, and halts on an illegal opcode or a halt request.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             leave IDLE and begin fetching at pc
//   halt_req          stop once the current instruction retires (sampled in WRITEBACK)
//   imem_req/addr     fetch request and address (addr == pc)
//   imem_ready/rdata  fetch handshake and returned instruction
//   ir, opcode        instruction register and its opcode field to the control unit
//   dec_reg_write     RegWrite from the control unit
//   dec_jump          Jump from the control unit
//   alu_en            one-cycle ALU capture strobe (EXECUTE)
//   rf_we             one-cycle register-file write strobe (WRITEBACK)
//   pc                program counter
//   busy, halted      status: active / in HALT
//   illegal           sticky illegal-opcode flag
//   retired           saturating retired-instruction count
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [5:0]         opcode,
  input  logic               dec_reg_write,
  input  logic               dec_jump,
  output logic               alu_en,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_nxt;
  logic [CNT_W-1:0]   r_retired;
  logic [CNT_W-1:0]   w_retired_nxt;
  logic               r_illegal;
  logic               w_illegal_nxt;
  logic [5:0]         w_opcode;

  assign w_opcode = r_ir[INSTR_W-1 -: 6];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_retired <= w_retired_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_retired_nxt = r_retired;
    w_illegal_nxt = r_illegal;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal_opcode(w_opcode)) begin
          w_state_nxt = S_EXECUTE;
        end else begin
          w_state_nxt   = S_HALT;
          w_illegal_nxt = 1'b1;
        end
      end
      S_EXECUTE: begin
        w_state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // pc+1 wraps naturally at PC_W bits
        w_pc_nxt = dec_jump ? r_ir[PC_W-1:0] : r_pc + PC_W'(1);
        if (r_retired != {CNT_W{1'b1}}) w_retired_nxt = r_retired + CNT_W'(1);
        w_state_nxt = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are masked by rst so nothing can fire in the cycle reset rises,
  // even before the async clear has propagated through r_state.
  assign imem_req  = (r_state == S_FETCH) & ~rst;
  assign alu_en    = (r_state == S_EXECUTE) & ~rst;
  assign rf_we     = (r_state == S_WRITEBACK) & dec_reg_write & ~rst;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign opcode    = w_opcode;
  assign retired   = r_retired;
  assign illegal   = r_illegal;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT) && !rst;
  assign halted    = (r_state == S_HALT) && !rst;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        dec_reg_write;
  logic        dec_jump;
  logic        alu_en;
  logic        rf_we;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  // narrow-counter instance: same stimulus, retired saturates at 7
  logic        s_imem_req;
  logic [7:0]  s_imem_addr;
  logic [31:0] s_ir;
  logic [5:0]  s_opcode;
  logic        s_dec_reg_write;
  logic        s_dec_jump;
  logic        s_alu_en;
  logic        s_rf_we;
  logic [7:0]  s_pc;
  logic        s_busy;
  logic        s_halted;
  logic        s_illegal;
  logic [2:0]  s_retired;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] legal_ops [5] = '{6'b000000, 6'b001000, 6'b001001, 6'b001010, 6'b000010};

  // reference model state
  logic [7:0]  m_pc;
  int          m_ret;

  instr_sequencer #(.PC_W(8), .INSTR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_jump(dec_jump),
    .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .busy(busy),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  instr_sequencer #(.PC_W(8), .INSTR_W(32), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir(s_ir), .opcode(s_opcode),
    .dec_reg_write(s_dec_reg_write), .dec_jump(s_dec_jump),
    .alu_en(s_alu_en), .rf_we(s_rf_we), .pc(s_pc), .busy(s_busy),
    .halted(s_halted), .illegal(s_illegal), .retired(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_legal(input logic [5:0] op);
    for (int k = 0; k < 5; k++) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // behavioural control unit
  function automatic bit ctrl_rw(input logic [5:0] op);
    return ref_legal(op) && (op != 6'b000010);
  endfunction

  function automatic bit ctrl_j(input logic [5:0] op);
    return op == 6'b000010;
  endfunction

  assign dec_reg_write   = ctrl_rw(opcode);
  assign dec_jump        = ctrl_j(opcode);
  assign s_dec_reg_write = ctrl_rw(s_opcode);
  assign s_dec_jump      = ctrl_j(s_opcode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_legal(input bit allow_jump);
    logic [5:0] op;
    op = legal_ops[$urandom_range(0, allow_jump ? 4 : 3)];
    return {op, 26'($urandom)};
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [5:0] op;
    op = 6'($urandom);
    while (ref_legal(op)) op = 6'($urandom);
    return {op, 26'($urandom)};
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_alu"}, alu_en, 0);
    chk({tag, "_rfwe"}, rf_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_ret"}, retired, 0);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_sret"}, s_retired, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    m_pc = '0;
    m_ret = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", imem_req, 1);
    chk("start_busy", busy, 1);
  endtask

  // Starts at a negedge in FETCH; returns at the negedge after the instruction ends.
  task automatic run_instr(input logic [31:0] instr, input int waits, input bit hreq);
    int          cyc;
    int          n_alu;
    int          n_rf;
    bit          both;
    bit          legal;
    logic [31:0] ir_before;
    legal    = ref_legal(instr[31:26]);
    halt_req = hreq;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    ir_before = ir;
    cyc = 0;
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      cyc++;
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_ir", ir, ir_before);
    end
    imem_ready = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    cyc++;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("ir_load", ir, instr);
    chk("opcode", opcode, instr[31:26]);
    n_alu = 0; n_rf = 0; both = 0;
    for (int g = 0; g < 12 && !imem_req && !halted; g++) begin
      if (alu_en) n_alu++;
      if (rf_we) n_rf++;
      if (alu_en && rf_we) both = 1;
      @(negedge clk);
      cyc++;
    end
    if (legal) begin
      if (ctrl_j(instr[31:26])) m_pc = instr[7:0];
      else m_pc = m_pc + 8'd1;
      if (m_ret < 65535) m_ret++;
      chk("cycles", cyc, waits + 4);
      chk("alu_pulses", n_alu, 1);
      chk("rf_pulses", n_rf, ctrl_rw(instr[31:26]) ? 1 : 0);
      chk("strobe_overlap", both, 0);
      chk("pc", pc, m_pc);
      chk("retired", retired, m_ret);
      chk("s_retired", s_retired, (m_ret > 7) ? 7 : m_ret);
      chk("halted", halted, hreq);
      chk("next_req", imem_req, !hreq);
      chk("illegal_clear", illegal, 0);
      if (!hreq) chk("next_addr", imem_addr, m_pc);
    end else begin
      chk("ill_cycles", cyc, waits + 2);
      chk("ill_alu", n_alu, 0);
      chk("ill_rf", n_rf, 0);
      chk("ill_halted", halted, 1);
      chk("ill_flag", illegal, 1);
      chk("ill_busy", busy, 0);
      chk("ill_pc", pc, m_pc);
      chk("ill_retired", retired, m_ret);
    end
    halt_req = 1'b0;
  endtask

  task automatic check_start_ignored();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_sticky", halted, 1);
      chk("halt_noreq", imem_req, 0);
      chk("halt_pc", pc, m_pc);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    m_pc = '0; m_ret = 0;

    // basic flow, jump, wait states, random mix, halt request
    do_reset();
    do_start();
    run_instr({6'b001000, 26'h0000123}, 0, 1'b0);
    for (int k = 0; k < 4; k++) run_instr(rand_legal(1'b0), 0, 1'b0);
    chk("pc_before_j", pc, 8'h05);
    run_instr({6'b000010, 26'h000002A}, 0, 1'b0);
    chk("jump_target", imem_addr, 8'h2A);
    run_instr({6'b001000, 26'h0000456}, 3, 1'b0);
    for (int k = 0; k < 40; k++) run_instr(rand_legal(1'b1), $urandom_range(0, 3), 1'b0);
    run_instr(rand_legal(1'b0), $urandom_range(0, 2), 1'b1);
    check_start_ignored();

    // illegal opcode at pc 3
    do_reset();
    do_start();
    for (int k = 0; k < 3; k++) run_instr({6'b000000, 26'($urandom)}, 0, 1'b0);
    run_instr({6'b111111, 26'h0}, 0, 1'b0);
    chk("ill_pc3", pc, 8'h03);
    check_start_ignored();

    // random illegal opcode with wait states
    do_reset();
    do_start();
    run_instr(rand_legal(1'b0), 1, 1'b0);
    run_instr(rand_illegal(), 2, 1'b0);

    // pc wrap through 0xFF
    do_reset();
    do_start();
    for (int k = 0; k < 256; k++) run_instr({6'b000000, 26'($urandom)}, 0, 1'b0);
    chk("pc_wrap", pc, 8'h00);
    chk("wrap_retired", retired, 256);
    chk("sat_small", s_retired, 3'd7);

    // reset mid-EXECUTE
    do_reset();
    do_start();
    imem_ready = 1'b1;
    imem_rdata = {6'b001000, 26'h1};
    begin
      bit seen;
      seen = 0;
      for (int g = 0; g < 10 && !seen; g++) begin
        @(negedge clk);
        imem_ready = 1'b0;
        if (alu_en) seen = 1;
      end
      chk("reach_execute", seen, 1);
    end
    #1 rst = 1'b1;
    #1 check_reset_values("rst_exec");
    @(negedge clk);
    chk("rst_exec_rfwe", rf_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_idle", busy, 0);
    chk("rst_exec_noreq", imem_req, 0);

    // reset mid-FETCH with imem_req high
    do_reset();
    do_start();
    @(negedge clk);
    chk("mid_fetch_req", imem_req, 1);
    #1 rst = 1'b1;
    #1 check_reset_values("rst_fetch");
    @(negedge clk);
    chk("rst_fetch_rfwe", rf_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fetch_idle", busy, 0);
    chk("rst_fetch_noreq", imem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
